// File: rtl/ring_step_div.sv
// N-position up/down one-hot ring stepped once per programmable prescaler period.
// Ports: clk, clear_n (async low), en, reset (sync), ud, div -> q, pos, tick, div_clk.
module ring_step_div #(
  parameter int N     = 4,
  parameter int DIV_W = 4,
  parameter int PW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             reset,
  input  logic             ud,
  input  logic [DIV_W-1:0] div,
  output logic [N-1:0]     q,
  output logic [PW-1:0]    pos,
  output logic             tick,
  output logic             div_clk
);

  localparam logic [PW:0]   NL   = (PW+1)'(N);
  localparam logic [PW-1:0] PMAX = PW'(N-1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] d_act;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W:0]   half;
  logic             wrap;
  logic             legal;
  logic [PW-1:0]    pos_nx;

  assign div_eff = (div == '0) ? DIV_W'(1) : div;
  assign wrap    = (cnt == d_act - DIV_W'(1));
  assign legal   = ({1'b0, pos} < NL);
  assign tick    = en & ~reset & wrap & legal;

  // High for the first ceil(D/2) counts of each period.
  assign half    = ({1'b0, d_act} + (DIV_W+1)'(1)) >> 1;
  assign div_clk = ({1'b0, cnt} < half);

  always_comb begin
    pos_nx = pos;
    if (ud)
      pos_nx = (pos == PMAX) ? '0 : pos + PW'(1);
    else
      pos_nx = (pos == '0) ? PMAX : pos - PW'(1);
  end

  for (genvar i = 0; i < N; i++) begin : g_q
    assign q[i] = (pos == PW'(i));
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt   <= '0;
      d_act <= DIV_W'(1);
      pos   <= '0;
    end else if (reset) begin
      cnt   <= '0;
      pos   <= '0;
      d_act <= div_eff;
    end else if (!legal) begin
      pos <= '0;
    end else if (en) begin
      if (wrap) begin
        cnt   <= '0;
        d_act <= div_eff;
        pos   <= pos_nx;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ring_step_div.sv
// Directed scoreboard bench for ring_step_div (N=4 main instance, N=5 for
// illegal-state recovery).
module tb_ring_step_div;

  typedef struct {
    logic       tick;
    logic [2:0] pos;
    logic [7:0] q;
    logic       dclk;
  } exp_t;

  logic       clk;
  logic       clear_n, en, reset, ud;
  logic [3:0] div;
  logic [3:0] q;
  logic [1:0] pos;
  logic       tick, div_clk;

  logic       b_clear_n, b_en, b_reset, b_ud;
  logic [3:0] b_div;
  logic [4:0] b_q;
  logic [2:0] b_pos;
  logic       b_tick, b_div_clk;

  exp_t sb[$];
  exp_t sb5[$];
  int checks = 0;
  int errors = 0;

  ring_step_div #(.N(4), .DIV_W(4)) dut (
    .clk(clk), .clear_n(clear_n), .en(en), .reset(reset), .ud(ud),
    .div(div), .q(q), .pos(pos), .tick(tick), .div_clk(div_clk)
  );

  ring_step_div #(.N(5), .DIV_W(4)) dut_b (
    .clk(clk), .clear_n(b_clear_n), .en(b_en), .reset(b_reset), .ud(b_ud),
    .div(b_div), .q(b_q), .pos(b_pos), .tick(b_tick), .div_clk(b_div_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] onehot(input logic [2:0] p, input int n);
    logic [7:0] one;
    one = 8'd1;
    return (int'(p) < n) ? (one << p) : 8'h00;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("tick", 8'(tick), 8'(e.tick));
      chk("pos", 8'(pos), 8'(e.pos));
      chk("q", 8'(q), 8'(e.q[3:0]));
      chk("div_clk", 8'(div_clk), 8'(e.dclk));
    end
  end

  always @(negedge clk) begin
    if (sb5.size() > 0) begin
      exp_t e;
      e = sb5.pop_front();
      chk("b_tick", 8'(b_tick), 8'(e.tick));
      chk("b_pos", 8'(b_pos), 8'(e.pos));
      chk("b_q", 8'(b_q), 8'(e.q[4:0]));
      chk("b_div_clk", 8'(b_div_clk), 8'(e.dclk));
    end
  end

  task automatic push(input logic t, input logic [2:0] p, input logic dc);
    exp_t e;
    e.tick = t;
    e.pos  = p;
    e.q    = onehot(p, 4);
    e.dclk = dc;
    sb.push_back(e);
  endtask

  task automatic step(input logic e, input logic r, input logic u,
                      input logic [3:0] d, input logic t,
                      input logic [2:0] p, input logic dc);
    @(posedge clk);
    #1;
    en = e; reset = r; ud = u; div = d;
    push(t, p, dc);
  endtask

  task automatic push5(input logic t, input logic [2:0] p, input logic dc);
    exp_t e;
    e.tick = t;
    e.pos  = p;
    e.q    = onehot(p, 5);
    e.dclk = dc;
    sb5.push_back(e);
  endtask

  initial begin
    clear_n = 0; en = 0; reset = 0; ud = 1; div = 0;
    b_clear_n = 0; b_en = 0; b_reset = 0; b_ud = 1; b_div = 0;

    // held in clear: tick follows en & ~reset only
    step(0, 0, 1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 1, 0, 1);
    step(1, 1, 1, 0, 0, 0, 1);
    @(negedge clk); #1;
    en = 0; reset = 0; clear_n = 1;

    // bypass ratio, up
    step(1, 0, 1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1, 1, 1);
    step(1, 0, 1, 0, 1, 2, 1);
    step(1, 0, 1, 0, 1, 3, 1);
    step(1, 0, 1, 0, 1, 0, 1);

    // reset pulse loads 3, then count down
    step(1, 1, 0, 3, 0, 1, 1);
    step(1, 0, 0, 3, 0, 0, 1);
    step(1, 0, 0, 3, 0, 0, 1);
    step(1, 0, 0, 3, 1, 0, 0);
    step(1, 0, 0, 3, 0, 3, 1);
    step(1, 0, 0, 3, 0, 3, 1);
    step(1, 0, 0, 3, 1, 3, 0);
    step(1, 0, 0, 3, 0, 2, 1);
    step(1, 0, 0, 3, 0, 2, 1);
    step(1, 0, 0, 3, 1, 2, 0);
    step(1, 0, 0, 3, 0, 1, 1);
    step(1, 0, 0, 3, 0, 1, 1);
    step(1, 0, 0, 3, 1, 1, 0);

    // ratio 5, switched to 2 at cnt=2
    step(1, 1, 1, 5, 0, 0, 1);
    step(1, 0, 1, 5, 0, 0, 1);
    step(1, 0, 1, 5, 0, 0, 1);
    step(1, 0, 1, 2, 0, 0, 1);
    step(1, 0, 1, 2, 0, 0, 0);
    step(1, 0, 1, 2, 1, 0, 0);
    step(1, 0, 1, 2, 0, 1, 1);
    step(1, 0, 1, 2, 1, 1, 0);
    step(1, 0, 1, 2, 0, 2, 1);
    step(1, 0, 1, 2, 1, 2, 0);

    // load ratio 4
    step(1, 0, 1, 4, 0, 3, 1);
    step(1, 0, 1, 4, 1, 3, 0);

    // enable gaps: 4 enabled cycles per tick
    step(1, 0, 1, 4, 0, 0, 1);
    step(0, 0, 1, 4, 0, 0, 1);
    step(0, 0, 1, 4, 0, 0, 1);
    step(1, 0, 1, 4, 0, 0, 1);
    step(1, 0, 1, 4, 0, 0, 0);
    step(0, 0, 1, 4, 0, 0, 0);
    step(1, 0, 1, 4, 1, 0, 0);
    step(1, 0, 1, 4, 0, 1, 1);
    step(1, 0, 1, 4, 0, 1, 1);
    step(1, 0, 1, 4, 0, 1, 0);
    // reset with tick pending
    step(1, 1, 1, 4, 0, 1, 0);
    step(0, 0, 1, 4, 0, 0, 1);

    // walk to pos=2, cnt=1
    step(1, 0, 1, 4, 0, 0, 1);
    step(1, 0, 1, 4, 0, 0, 1);
    step(1, 0, 1, 4, 0, 0, 0);
    step(1, 0, 1, 4, 1, 0, 0);
    step(1, 0, 1, 4, 0, 1, 1);
    step(1, 0, 1, 4, 0, 1, 1);
    step(1, 0, 1, 4, 0, 1, 0);
    step(1, 0, 1, 4, 1, 1, 0);
    step(1, 0, 1, 4, 0, 2, 1);
    step(0, 0, 1, 4, 0, 2, 1);

    // asynchronous clear between edges
    @(posedge clk); #1;
    en = 0;
    #2 clear_n = 0;
    push(0, 0, 1);
    @(negedge clk); #1;
    clear_n = 1;
    step(1, 0, 1, 4, 1, 0, 1);
    step(0, 0, 1, 4, 0, 1, 1);

    // N=5 instance: illegal position recovery
    @(negedge clk); #1;
    b_clear_n = 1;
    @(posedge clk); #1;
    push5(0, 0, 1);
    @(posedge clk); #1;
    force dut_b.pos = 3'd6;
    #1;
    b_en = 1;
    push5(0, 6, 1);
    @(negedge clk); #1;
    b_en = 0;
    release dut_b.pos;
    @(posedge clk); #1;
    push5(0, 0, 1);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || sb5.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", sb.size(), sb5.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
